// File: rtl/lvt_table_4port.sv
// Live value table for the 4-port multiported data cache.
// Each entry records which accelerator port last wrote that word address.
// Read results are registered, so they line up with the one-cycle data-bank BRAM reads.
module lvt_table_4port #(
    parameter int ADDR_W  = 6,
    parameter int ENTRY_W = 2,
    parameter int NPORTS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NPORTS-1:0]         wr_en,
    input  logic [NPORTS*ADDR_W-1:0]  wr_addr,
    input  logic [NPORTS-1:0]         rd_en,
    input  logic [NPORTS*ADDR_W-1:0]  rd_addr,
    output logic [NPORTS*ENTRY_W-1:0] rd_sel,
    output logic [NPORTS-1:0]         rd_valid,
    output logic                      wr_conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [ENTRY_W-1:0] lvt_q [DEPTH];
    logic [ENTRY_W-1:0] lvt_d [DEPTH];
    logic               collision;

    // Next table contents. Flush clears everything and masks writes.
    // Ports are applied in ascending order, so the highest index wins a collision.
    // Reads index this next-state view, which gives write-first forwarding.
    always_comb begin
        lvt_d = lvt_q;
        if (flush) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                lvt_d[a] = '0;
            end
        end else begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                if (wr_en[k]) begin
                    lvt_d[wr_addr[k*ADDR_W +: ADDR_W]] = ENTRY_W'(k);
                end
            end
        end
    end

    // Flag any pair of enabled write ports that target the same address.
    always_comb begin
        collision = 1'b0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            for (int unsigned j = i + 1; j < NPORTS; j++) begin
                if (wr_en[i] && wr_en[j] &&
                    (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
                    collision = 1'b1;
                end
            end
        end
    end

    // Table state plus the registered read results and conflict pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvt_q       <= '{default: '0};
            rd_sel      <= '0;
            rd_valid    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            lvt_q <= lvt_d;
            for (int unsigned k = 0; k < NPORTS; k++) begin
                if (rd_en[k]) begin
                    rd_sel[k*ENTRY_W +: ENTRY_W] <= lvt_d[rd_addr[k*ADDR_W +: ADDR_W]];
                end
            end
            rd_valid    <= rd_en;
            wr_conflict <= collision & ~flush;
        end
    end

endmodule

// File: tb/tb_lvt_table_4port.sv
// Self-checking bench for lvt_table_4port: directed cases with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_lvt_table_4port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  wr_en = '0;
    logic [23:0] wr_addr = '0;
    logic [3:0]  rd_en = '0;
    logic [23:0] rd_addr = '0;
    logic [7:0]  rd_sel;
    logic [3:0]  rd_valid;
    logic        wr_conflict;

    int n_cmp = 0;
    int n_err = 0;
    logic started = 1'b0;

    lvt_table_4port #(.ADDR_W(6), .ENTRY_W(2), .NPORTS(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_sel(rd_sel), .rd_valid(rd_valid), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int         m_mem [64];
    int         m_sel [4];
    logic [3:0] m_valid = '0;
    logic       m_conf = 1'b0;
    int         cnt [64];

    function automatic int waddr_of(int k);
        logic [23:0] w;
        w = wr_addr;
        return int'(w[k*6 +: 6]);
    endfunction

    function automatic int raddr_of(int k);
        logic [23:0] r;
        r = rd_addr;
        return int'(r[k*6 +: 6]);
    endfunction

    // Highest-numbered enabled write port targeting addr, or -1 if none.
    function automatic int last_writer(int addr);
        int w = -1;
        for (int k = 0; k < 4; k++)
            if (wr_en[k] && waddr_of(k) == addr && k > w) w = k;
        return w;
    endfunction

    initial begin
        foreach (m_mem[a]) m_mem[a] = 0;
        foreach (m_sel[k]) m_sel[k] = 0;
    end

    // Reference model: what the outputs must be after each rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            foreach (m_mem[a]) m_mem[a] = 0;
            foreach (m_sel[k]) m_sel[k] = 0;
            m_valid = '0;
            m_conf  = 1'b0;
        end else begin
            foreach (cnt[a]) cnt[a] = 0;
            if (!flush)
                for (int k = 0; k < 4; k++) if (wr_en[k]) cnt[waddr_of(k)]++;
            m_conf = 1'b0;
            foreach (cnt[a]) if (cnt[a] > 1) m_conf = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (rd_en[k]) begin
                    int w;
                    w = last_writer(raddr_of(k));
                    if (flush)       m_sel[k] = 0;
                    else if (w >= 0) m_sel[k] = w;
                    else             m_sel[k] = m_mem[raddr_of(k)];
                end
            end
            m_valid = rd_en;
            if (flush) begin
                foreach (m_mem[a]) m_mem[a] = 0;
            end else begin
                for (int a = 0; a < 64; a++) begin
                    int w;
                    w = last_writer(a);
                    if (w >= 0) m_mem[a] = w;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle against the model once reset has been released.
    always @(negedge clk) begin
        if (started && !reset) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] s;
                s = rd_sel;
                chk($sformatf("model rd_sel[%0d]", k), int'(s[k*2 +: 2]), m_sel[k]);
            end
            chk("model rd_valid", int'(rd_valid), int'(m_valid));
            chk("model wr_conflict", int'(wr_conflict), int'(m_conf));
        end
    end

    function automatic logic [23:0] pk(int a0, int a1, int a2, int a3);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    // Apply one cycle of inputs; returns #1 after the edge that consumed them.
    task automatic step(input logic [3:0] we, input logic [23:0] wa,
                        input logic [3:0] re, input logic [23:0] ra, input logic fl);
        wr_en = we; wr_addr = wa; rd_en = re; rd_addr = ra; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(4'b0000, '0, 4'b0000, '0, 1'b0);
    endtask

    initial begin
        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("reset rd_sel", int'(rd_sel), 0);
        chk("reset rd_valid", int'(rd_valid), 0);
        chk("reset wr_conflict", int'(wr_conflict), 0);
        reset = 1'b0;
        started = 1'b1;

        // Read addr 5 on all ports after reset
        step(4'b0000, '0, 4'b1111, pk(5, 5, 5, 5), 1'b0);
        chk("post-reset rd_sel", int'(rd_sel), 0);
        chk("post-reset rd_valid", int'(rd_valid), 4'b1111);

        // Single write then read
        step(4'b0100, pk(0, 0, 10, 0), 4'b0000, '0, 1'b0);
        step(4'b0000, '0, 4'b0001, pk(10, 0, 0, 0), 1'b0);
        chk("single write rd_sel[0]", int'(rd_sel[1:0]), 2);
        chk("single write rd_valid", int'(rd_valid), 4'b0001);

        // Collision on addr 7
        step(4'b1010, pk(0, 7, 0, 7), 4'b0000, '0, 1'b0);
        chk("collision pulse", int'(wr_conflict), 1);
        idle();
        chk("collision one cycle", int'(wr_conflict), 0);
        step(4'b0000, '0, 4'b0100, pk(0, 0, 7, 0), 1'b0);
        chk("collision winner", int'(rd_sel[5:4]), 3);

        // Forwarding: entry 20 first holds 3, then port 1 overwrites while port 3 reads
        step(4'b1000, pk(0, 0, 0, 20), 4'b0000, '0, 1'b0);
        step(4'b0010, pk(0, 20, 0, 0), 4'b1000, pk(0, 0, 0, 20), 1'b0);
        chk("forward rd_sel[3]", int'(rd_sel[7:6]), 1);

        // Flush beats writes and masks their conflict
        step(4'b1111, pk(0, 1, 2, 3), 4'b0000, '0, 1'b0);
        step(4'b0000, '0, 4'b1111, pk(0, 1, 2, 3), 1'b0);
        chk("prefill rd_sel", int'(rd_sel), 8'b11_10_01_00);
        step(4'b1100, pk(0, 0, 1, 1), 4'b0000, '0, 1'b1);
        chk("flush no conflict", int'(wr_conflict), 0);
        step(4'b0000, '0, 4'b1111, pk(0, 1, 2, 3), 1'b0);
        chk("post-flush rd_sel", int'(rd_sel), 0);
        chk("post-flush conflict", int'(wr_conflict), 0);

        // Async reset between edges while reads are in flight
        step(4'b1111, pk(4, 5, 6, 7), 4'b0000, '0, 1'b0);
        step(4'b0000, '0, 4'b1111, pk(4, 5, 6, 7), 1'b0);
        chk("pre-reset rd_valid", int'(rd_valid), 4'b1111);
        chk("pre-reset rd_sel", int'(rd_sel), 8'b11_10_01_00);
        #2 reset = 1'b1;
        #1;
        chk("async reset rd_valid", int'(rd_valid), 0);
        chk("async reset rd_sel", int'(rd_sel), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(4'b0000, '0, 4'b1111, pk(4, 5, 6, 7), 1'b0);
        chk("entries cleared by reset", int'(rd_sel), 0);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            logic [23:0] wa, ra;
            for (int k = 0; k < 4; k++) begin
                wa[k*6 +: 6] = 6'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 63));
                ra[k*6 +: 6] = 6'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 63));
            end
            step(4'($urandom), wa, 4'($urandom), ra, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #1 chk("random async reset rd_valid", int'(rd_valid), 0);
                @(posedge clk); #1;
                reset = 1'b0;
            end
        end

        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
